ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer that sits beside the execute-stage ALU. It accepts one M-extension operation from EX and runs a shift-add multiply or a restoring divide over XLEN cycles. While it runs, it stalls the front of the pipeline (IF/ID/EX), then presents the result for one cycle so that the EX/MEM register captures it in place of the ALU result. The hazard/stall logic ORs stall_o into its existing stall terms.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start_i  input  1  EX holds a valid M-extension op (decoder MulDivE qualified by valid)
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  input  XLEN  rs1 operand (post-forwarding RD1E)
b_i  input  XLEN  rs2 operand (post-forwarding RD2E)
flush_i  input  1  EX flush (taken branch/jump older than this op)
stall_o  output  1  hold PC, IF/ID and ID/EX registers
busy_o  output  1  FSM not in IDLE
result_valid_o  output  1  one-cycle result strobe
result_o  output  XLEN  operation result, valid when result_valid_o=1

Behaviour:
- States: IDLE, CALC, DONE. On rst: IDLE, counter 0, accumulators 0; result_valid_o=0, result_o=0, busy_o=0, stall_o=0.
- IDLE: if start_i && !flush_i: latch op, convert operands to magnitudes per op signedness, record result sign, counter=XLEN-1.
  - Special cases go directly to DONE, where the result is available one cycle after accept:
    - Divide by zero: DIV/DIVU → all ones; REM/REMU → a_i.
    - Signed overflow (DIV/REM with a_i=0x80000000, b_i=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - Otherwise go to CALC.
- stall_o = (IDLE && start_i && !flush_i) || CALC. It is combinational, so the instruction stays in EX from its first cycle. stall_o=0 in DONE, so the pipeline advances at the end of DONE and EX/MEM captures result_o.
- CALC: one iteration per cycle. The counter decrements. At counter==0 → DONE.
  - Multiply: 2*XLEN product via shift-add on the low bit of the multiplier.
  - Divide: restoring shift-subtract, producing 1 quotient bit per cycle.
- Normal latency: accept at cycle N → result_valid_o at cycle N+XLEN+1 (33 for XLEN=32).
- DONE: result_valid_o=1 and result_o driven for exactly one cycle; start_i is ignored; next state IDLE. result_o holds its value after DONE until the next accept (result_valid_o=0).
- Sign fix-up is applied when entering DONE:
  - Product negated if signs differ. MULHSU treats b_i as unsigned.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Quotient negated if the operand signs differ; remainder takes the dividend's sign.
- flush_i in CALC or DONE → IDLE next cycle. No result_valid_o is produced for the flushed op, and stall_o drops in the same cycle as flush_i.
- flush_i and start_i together in IDLE → no accept.
- rst mid-operation → IDLE next edge; all outputs return to reset values.
- Back-to-back ops: the second op enters EX the cycle after DONE and is accepted in IDLE. There is no dead cycle beyond IDLE acceptance.

Test Plan:
- Reset: hold rst 2 cycles during CALC → busy_o=0, stall_o=0, result_valid_o=0, result_o=0.
- MUL 7×(-3) and MULH 0x80000000×0x80000000 → result_valid_o exactly 33 cycles after accept; results 0xFFFFFFEB and 0x40000000; stall_o high for 33 cycles, low in DONE.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF. Overflow: DIV 0x80000000/-1 → 0x80000000, REM → 0. Both produce result_valid_o one cycle after accept.
- Flush: assert flush_i 10 cycles into a DIV → stall_o falls the same cycle, IDLE next cycle, no result_valid_o; a new MULHU 0xFFFFFFFF×2 is then accepted → 0x00000001.
- Back-to-back: MUL then DIVU with start_i held by the stall → two result_valid_o pulses exactly 34 cycles apart, each the same cycle stall_o is low.

Source files
------------

// File: rtl/ex_muldiv_seq_if.sv
// Handshake/operand bundle between the EX stage and the multiply/divide sequencer.
interface ex_muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            result_valid_o;
    logic [XLEN-1:0] result_o;

    // EX-stage side: issues operations, consumes stall and result.
    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  stall_o, busy_o, result_valid_o, result_o
    );

    // Sequencer side.
    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output stall_o, busy_o, result_valid_o, result_o
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Shift-add multiply / restoring divide, one bit per cycle, result strobed for one cycle.
module ex_muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_muldiv_seq_if.slave       bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StDone} stateT;

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    stateT             stateQ, stateD;
    logic [CNT_W-1:0]  cntQ, cntD;
    logic [2*XLEN-1:0] accQ, accD;      // mul: {hi, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]   mcandQ, mcandD;  // multiplicand or divisor magnitude
    logic [2:0]        opQ, opD;
    logic              negQ, negD;      // result (product/quotient or remainder) needs negation
    logic [XLEN-1:0]   resultQ, resultD;

    // Operand decode for the op currently presented by EX.
    logic            isDiv, aSigned, bSigned, aNeg, bNeg;
    logic [XLEN-1:0] aMag, bMag;

    // Single iteration of the running operation and its final fix-up.
    logic [XLEN:0]     mulSum, divTrial;
    logic [2*XLEN-1:0] mulAcc, divAcc, stepAcc, prod;
    logic [XLEN-1:0]   quot, rem, fixed;

    // Decode signedness and form operand magnitudes.
    always_comb begin
        isDiv   = bus.op_i[2];
        // MUL low half is sign-agnostic, so it is handled as unsigned.
        aSigned = isDiv ? !bus.op_i[0] : (bus.op_i == 3'b001 || bus.op_i == 3'b010);
        bSigned = isDiv ? !bus.op_i[0] : (bus.op_i == 3'b001);
        aNeg    = aSigned && bus.a_i[XLEN-1];
        bNeg    = bSigned && bus.b_i[XLEN-1];
        aMag    = aNeg ? -bus.a_i : bus.a_i;
        bMag    = bNeg ? -bus.b_i : bus.b_i;
    end

    // One shift-add / shift-subtract step and the sign fix-up of its outcome.
    always_comb begin
        mulSum   = {1'b0, accQ[2*XLEN-1:XLEN]} + {1'b0, (accQ[0] ? mcandQ : {XLEN{1'b0}})};
        mulAcc   = {mulSum, accQ[XLEN-1:1]};
        divTrial = accQ[2*XLEN-1:XLEN-1] - {1'b0, mcandQ};
        divAcc   = divTrial[XLEN] ? {accQ[2*XLEN-2:0], 1'b0}
                                  : {divTrial[XLEN-1:0], accQ[XLEN-2:0], 1'b1};
        stepAcc  = opQ[2] ? divAcc : mulAcc;
        prod     = negQ ? -stepAcc : stepAcc;
        quot     = negQ ? -stepAcc[XLEN-1:0] : stepAcc[XLEN-1:0];
        rem      = negQ ? -stepAcc[2*XLEN-1:XLEN] : stepAcc[2*XLEN-1:XLEN];
        unique case (opQ)
            3'b000:          fixed = prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          fixed = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:  fixed = quot;
            default:         fixed = rem;
        endcase
    end

    // Next-state logic: accept, iterate, present result, flush.
    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        accD    = accQ;
        mcandD  = mcandQ;
        opD     = opQ;
        negD    = negQ;
        resultD = resultQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.start_i && !bus.flush_i) begin
                    opD  = bus.op_i;
                    cntD = CNT_W'(XLEN - 1);
                    negD = (isDiv && bus.op_i[1]) ? aNeg : (aNeg ^ bNeg);
                    if (isDiv && bus.b_i == '0) begin
                        resultD = bus.op_i[1] ? bus.a_i : {XLEN{1'b1}};
                        stateD  = StDone;
                    end else if (isDiv && !bus.op_i[0] && bus.a_i == MinNeg
                                 && bus.b_i == {XLEN{1'b1}}) begin
                        resultD = bus.op_i[1] ? {XLEN{1'b0}} : MinNeg;
                        stateD  = StDone;
                    end else begin
                        accD   = {{XLEN{1'b0}}, (isDiv ? aMag : bMag)};
                        mcandD = isDiv ? bMag : aMag;
                        stateD = StCalc;
                    end
                end
            end
            StCalc: begin
                if (bus.flush_i) begin
                    stateD = StIdle;
                end else begin
                    accD = stepAcc;
                    cntD = cntQ - CNT_W'(1);
                    if (cntQ == '0) begin
                        resultD = fixed;
                        stateD  = StDone;
                    end
                end
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= StIdle;
            cntQ    <= '0;
            accQ    <= '0;
            mcandQ  <= '0;
            opQ     <= '0;
            negQ    <= 1'b0;
            resultQ <= '0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            accQ    <= accD;
            mcandQ  <= mcandD;
            opQ     <= opD;
            negQ    <= negD;
            resultQ <= resultD;
        end
    end

    // Outputs; stall is combinational so the op is held in EX from its first cycle.
    always_comb begin
        bus.stall_o        = ((stateQ == StIdle) && bus.start_i && !bus.flush_i)
                           || ((stateQ == StCalc) && !bus.flush_i);
        bus.busy_o         = (stateQ != StIdle);
        bus.result_valid_o = (stateQ == StDone) && !bus.flush_i;
        bus.result_o       = resultQ;
    end
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for the RV32M multiply/divide sequencer.
module tb_ex_muldiv_seq;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ex_muldiv_seq_if #(.XLEN(32)) bus ();

    ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op (start held until DONE) and measure latency, stall cycles and result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stallCnt, output logic [31:0] res,
                          output logic stallAtValid);
        lat = -1;
        stallCnt = 0;
        res = 32'hxxxx_xxxx;
        stallAtValid = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.op_i = op;
        bus.a_i = a;
        bus.b_i = b;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.result_valid_o) begin
                lat = n;
                res = bus.result_o;
                stallAtValid = bus.stall_o;
                break;
            end
            if (bus.stall_o) stallCnt++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        int lat, sc;
        logic [31:0] res;
        logic sv;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.result_valid_o !== 1'b0
            || bus.result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_init: busy=%b stall=%b valid=%b result=%h, required 0 0 0 0",
                     bus.busy_o, bus.stall_o, bus.result_valid_o, bus.result_o);
        end
        // Leave a nonzero result behind, then reset in the middle of a divide.
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, lat, sc, res, sv);
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.op_i = 3'b100; bus.a_i = 32'd1000; bus.b_i = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_busy: busy=%b, required 1", bus.busy_o);
        end
        rst = 1'b1; bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.result_valid_o !== 1'b0
            || bus.result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_op: busy=%b stall=%b valid=%b result=%h, required 0 0 0 0",
                     bus.busy_o, bus.stall_o, bus.result_valid_o, bus.result_o);
        end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [3] = '{3'b000, 3'b001, 3'b011};
        logic [31:0] as  [3] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd2};
        logic [31:0] exp [3] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h0000_0001};
        int lat, sc;
        logic [31:0] res;
        logic sv;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], lat, sc, res, sv);
            checks++;
            if (res !== exp[i]) begin
                failures++;
                $display("FAIL mul_result[%0d]: got %h, required %h", i, res, exp[i]);
            end
            checks++;
            if (lat != 33) begin
                failures++;
                $display("FAIL mul_latency[%0d]: got %0d, required 33", i, lat);
            end
            checks++;
            if (sc != 33 || sv !== 1'b0) begin
                failures++;
                $display("FAIL mul_stall[%0d]: stall cycles %0d stall_in_done %b, required 33 0",
                         i, sc, sv);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'h10, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'd2};
        int lat, sc;
        logic [31:0] res;
        logic sv;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], lat, sc, res, sv);
            checks++;
            if (res !== exp[i] || lat != 33) begin
                failures++;
                $display("FAIL div_result[%0d]: got %h after %0d cycles, required %h after 33",
                         i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int lat, sc;
        logic [31:0] res;
        logic sv;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], lat, sc, res, sv);
            checks++;
            if (res !== exp[i] || lat != 1 || sv !== 1'b0) begin
                failures++;
                $display("FAIL special[%0d]: got %h lat %0d stall %b, required %h lat 1 stall 0",
                         i, res, lat, sv, exp[i]);
            end
        end
    endtask

    task automatic test_flush();
        int lat, sc, pulses;
        logic [31:0] res;
        logic sv;
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.op_i = 3'b100; bus.a_i = 32'd100; bus.b_i = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        bus.flush_i = 1'b1; bus.start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall: got %b, required 0", bus.stall_o);
        end
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: busy=%b, required 0", bus.busy_o);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid_o) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL flush_no_valid: got %0d pulses, required 0", pulses);
        end
        run_op(3'b011, 32'hFFFF_FFFF, 32'd2, lat, sc, res, sv);
        checks++;
        if (res !== 32'h1 || lat != 33) begin
            failures++;
            $display("FAIL flush_next_op: got %h lat %0d, required 00000001 lat 33", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [31:0] r1, r2;
        logic s1, s2;
        t1 = -1; t2 = -1; r1 = '0; r2 = '0; s1 = 1'b1; s2 = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.op_i = 3'b000; bus.a_i = 32'd6; bus.b_i = 32'd7;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.result_valid_o) begin
                if (t1 < 0) begin
                    t1 = n; r1 = bus.result_o; s1 = bus.stall_o;
                end else begin
                    t2 = n; r2 = bus.result_o; s2 = bus.stall_o;
                    break;
                end
            end
            @(posedge clk); #1;
            if (t1 >= 0 && bus.op_i == 3'b000) begin
                bus.op_i = 3'b101; bus.a_i = 32'd100; bus.b_i = 32'd7;
            end
        end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        checks++;
        if (t1 < 0 || t2 - t1 != 34) begin
            failures++;
            $display("FAIL b2b_spacing: first %0d second %0d, required 34 apart", t1, t2);
        end
        checks++;
        if (r1 !== 32'd42 || r2 !== 32'd14) begin
            failures++;
            $display("FAIL b2b_results: got %h %h, required 0000002a 0000000e", r1, r2);
        end
        checks++;
        if (s1 !== 1'b0 || s2 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall: got %b %b, required 0 0", s1, s2);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.op_i = 3'b000;
        bus.a_i = '0;
        bus.b_i = '0;
        bus.flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
